// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port index and response kinds.
package dmem_arb_pkg;
   localparam int NUM_PORTS = 2;
   localparam int PORT_W    = 1;

   typedef logic [PORT_W-1:0] port_t;

   typedef enum logic {IDLE, RD_WAIT} state_t;

   typedef enum logic [1:0] {RSP_RD, RSP_WR, RSP_ERR} rsp_kind_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester grant select: round-robin against last_grant, or fixed priority to port 0.
module rr_arbiter2
   import dmem_arb_pkg::*;
#(
   parameter bit RR_ENABLE = 1'b1
)(
   input  logic [NUM_PORTS-1:0] req_valid,
   input  port_t                last_grant,
   output port_t                grant
);

   always_comb begin
      grant = port_t'(0);
      if (&req_valid)
         grant = RR_ENABLE ? ~last_grant : port_t'(0);
      else if (req_valid[1])
         grant = port_t'(1);
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and the host loader (port 1),
// rejecting misaligned accesses and returning a registered, port-tagged response.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter bit RR_ENABLE = 1'b1
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             req_valid,
   output logic [NUM_PORTS-1:0]             req_ready,
   input  logic [NUM_PORTS-1:0]             req_we,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata,
   output logic [NUM_PORTS-1:0]             resp_valid,
   output logic                             resp_err,
   output logic [DATA_W-1:0]                resp_rdata,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic                             mem_r_enable,
   output logic                             mem_w_enable,
   output logic [DATA_W-1:0]                mem_wdata,
   input  logic [DATA_W-1:0]                mem_rdata
);

   state_t    state;
   port_t     last_grant;
   port_t     rd_port;
   port_t     grant;
   logic      accept;
   logic      misaligned;
   rsp_kind_t kind;

   rr_arbiter2 #(.RR_ENABLE(RR_ENABLE)) u_arb (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // rst_n gates the handshake so nothing is offered to memory while reset is held.
   always_comb begin
      accept       = rst_n && (state == IDLE) && req_valid[grant];
      misaligned   = |req_addr[grant][1:0];
      kind         = misaligned ? RSP_ERR : (req_we[grant] ? RSP_WR : RSP_RD);
      req_ready    = '0;
      req_ready[grant] = accept;
      mem_addr     = req_addr[grant];
      mem_wdata    = req_wdata[grant];
      mem_r_enable = accept && (kind == RSP_RD);
      mem_w_enable = accept && (kind == RSP_WR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= port_t'(1);
         rd_port    <= port_t'(0);
         resp_valid <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  last_grant <= grant;
                  if (kind == RSP_RD) begin
                     state   <= RD_WAIT;
                     rd_port <= grant;
                  end else begin
                     resp_valid[grant] <= 1'b1;
                     resp_err          <= (kind == RSP_ERR);
                  end
               end
            end
            // Memory read data is valid now; present it next cycle while IDLE takes new grants.
            RD_WAIT: begin
               resp_valid[rd_port] <= 1'b1;
               resp_rdata          <= mem_rdata;
               state               <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side and checks both every
// cycle against a transaction-level model (free/busy, last winner, shadow memory).
module tb_dmem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [1:0]    v;
      logic          err;
      logic [DW-1:0] d;
   } rsp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]             rv   [2];
   logic [1:0]             rwe  [2];
   logic [1:0][AW-1:0]     ra   [2];
   logic [1:0][DW-1:0]     rwd  [2];
   logic [1:0]             rdy  [2];
   logic [1:0]             rspv [2];
   logic                   rerr [2];
   logic [DW-1:0]          rrd  [2];
   logic [AW-1:0]          maddr[2];
   logic                   mre  [2];
   logic                   mwe  [2];
   logic [DW-1:0]          mwd  [2];
   logic [DW-1:0]          mrd  [2];

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_ENABLE(1'b1)) u_rr (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
      .req_addr(ra[0]), .req_wdata(rwd[0]), .resp_valid(rspv[0]), .resp_err(rerr[0]),
      .resp_rdata(rrd[0]), .mem_addr(maddr[0]), .mem_r_enable(mre[0]),
      .mem_w_enable(mwe[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_ENABLE(1'b0)) u_fp (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
      .req_addr(ra[1]), .req_wdata(rwd[1]), .resp_valid(rspv[1]), .resp_err(rerr[1]),
      .resp_rdata(rrd[1]), .mem_addr(maddr[1]), .mem_r_enable(mre[1]),
      .mem_w_enable(mwe[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));

   int vectors = 0;
   int errors  = 0;

   // Model state; instance 0 is round-robin, instance 1 fixed priority.
   int            busy[2];
   int            lg  [2];
   int            gsel[2];
   int            gcnt[2][2];
   rsp_t          cur [2];
   rsp_t          nx  [2];
   logic [DW-1:0] sh  [2][64];
   logic [DW-1:0] mem [2][64];
   logic          op_we[2], op_re[2];
   logic [5:0]    op_a [2];
   logic [DW-1:0] op_d [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      busy[k] = 0;
      lg[k]   = 1;
      cur[k]  = '0;
      nx[k]   = '0;
   endtask

   task automatic check_inst(input int k);
      int         g;
      logic [1:0] er;
      logic       mis, ere, ewe;
      g = -1; er = 2'b00; mis = 1'b0; ere = 1'b0; ewe = 1'b0;
      if (rst_n && busy[k] == 0 && rv[k] != 2'b00) begin
         if (rv[k] == 2'b11) g = (k == 0) ? 1 - lg[k] : 0;
         else                g = rv[k][1] ? 1 : 0;
      end
      if (g >= 0) begin
         er[g] = 1'b1;
         mis   = (ra[k][g][1:0] != 2'b00);
         ere   = !mis && !rwe[k][g];
         ewe   = !mis && rwe[k][g];
      end
      chk($sformatf("ready_i%0d", k), rdy[k], er);
      chk($sformatf("r_en_i%0d", k), mre[k], ere);
      chk($sformatf("w_en_i%0d", k), mwe[k], ewe);
      if (ere || ewe) chk($sformatf("maddr_i%0d", k), maddr[k], ra[k][g]);
      if (ewe)        chk($sformatf("mwdata_i%0d", k), mwd[k], rwd[k][g]);
      chk($sformatf("resp_v_i%0d", k), rspv[k], cur[k].v);
      chk($sformatf("resp_err_i%0d", k), rerr[k], cur[k].err);
      chk($sformatf("resp_rd_i%0d", k), rrd[k], cur[k].d);
      gsel[k] = g;
      for (int p = 0; p < 2; p++) gcnt[k][p] += int'(rdy[k][p]);
      op_we[k] = mwe[k]; op_re[k] = mre[k]; op_a[k] = maddr[k][7:2]; op_d[k] = mwd[k];
   endtask

   task automatic update_inst(input int k);
      int g;
      g = gsel[k];
      if (op_we[k]) mem[k][op_a[k]] = op_d[k];
      if (op_re[k]) mrd[k] = mem[k][op_a[k]];
      cur[k] = nx[k];
      nx[k]  = '0;
      if (busy[k] != 0) busy[k] = 0;
      else if (g >= 0) begin
         lg[k]    = g;
         rv[k][g] = 1'b0;
         if (ra[k][g][1:0] != 2'b00) begin
            cur[k].v[g] = 1'b1; cur[k].err = 1'b1;
         end else if (rwe[k][g]) begin
            sh[k][ra[k][g][7:2]] = rwd[k][g];
            cur[k].v[g] = 1'b1;
         end else begin
            nx[k].v[g] = 1'b1;
            nx[k].d    = sh[k][ra[k][g][7:2]];
            busy[k]    = 1;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_inst(0); check_inst(1);
      @(posedge clk);
      #1;
      update_inst(0); update_inst(1);
   endtask

   task automatic set_req(input int k, input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      rv[k][p] = 1'b1; rwe[k][p] = we; ra[k][p] = a; rwd[k][p] = d;
   endtask

   task automatic new_req(input int k, input int p);
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      set_req(k, p, 1'($urandom_range(0, 1)), a, DW'($urandom));
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rv[k] = '0; rwe[k] = '0; ra[k] = '0; rwd[k] = '0; mrd[k] = '0;
         for (int i = 0; i < 64; i++) begin
            mem[k][i] = 32'h1000_0000 + DW'(i);
            sh[k][i]  = 32'h1000_0000 + DW'(i);
         end
         for (int p = 0; p < 2; p++) gcnt[k][p] = 0;
         model_reset(k);
      end
      repeat (3) cycle();
      rst_n = 1'b1;

      // Both ports hold reads: RR alternates 0,1,0,1; fixed priority starves port 1.
      for (int c = 0; c < 8; c++) begin
         for (int k = 0; k < 2; k++) begin
            set_req(k, 0, 1'b0, 32'h20, '0);
            set_req(k, 1, 1'b0, 32'h40, '0);
         end
         cycle();
      end
      chk("rr_grants_p0", gcnt[0][0], 2);
      chk("rr_grants_p1", gcnt[0][1], 2);
      chk("fp_grants_p0", gcnt[1][0], 4);
      chk("fp_grants_p1", gcnt[1][1], 0);
      for (int k = 0; k < 2; k++) rv[k] = '0;
      repeat (2) cycle();

      // Write then read back through port 0.
      for (int k = 0; k < 2; k++) set_req(k, 0, 1'b1, 32'h10, 32'hDEADBEEF);
      cycle();
      for (int k = 0; k < 2; k++) begin
         chk("wr_ack_v", rspv[k], 2'b01);
         chk("wr_ack_data", rrd[k], 0);
         set_req(k, 0, 1'b0, 32'h10, '0);
      end
      cycle();
      cycle();
      for (int k = 0; k < 2; k++) begin
         chk("rd_v", rspv[k], 2'b01);
         chk("rd_err", rerr[k], 0);
         chk("rd_data", rrd[k], 32'hDEADBEEF);
      end

      // Misaligned read from port 1.
      for (int k = 0; k < 2; k++) set_req(k, 1, 1'b0, 32'h22, '0);
      cycle();
      for (int k = 0; k < 2; k++) begin
         chk("mis_v", rspv[k], 2'b10);
         chk("mis_err", rerr[k], 1);
         chk("mis_data", rrd[k], 0);
      end

      // Back-to-back writes from port 1: one accept and one ack per cycle.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < 2; k++) set_req(k, 1, 1'b1, 32'h80 + AW'(4 * i), DW'($urandom));
         cycle();
         for (int k = 0; k < 2; k++) chk("b2b_ack", rspv[k], 2'b10);
      end
      cycle();

      // Reset during RD_WAIT drops the read; first tie afterwards goes to port 0.
      for (int k = 0; k < 2; k++) set_req(k, 0, 1'b0, 32'h10, '0);
      cycle();
      for (int k = 0; k < 2; k++) begin
         set_req(k, 0, 1'b0, 32'h30, '0);
         set_req(k, 1, 1'b0, 32'h34, '0);
      end
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) model_reset(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ready", rdy[k], 0);
         chk("rst_r_en", mre[k], 0);
         chk("rst_resp_v", rspv[k], 0);
      end
      repeat (2) cycle();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) gcnt[k][0] = 0;
      cycle();
      chk("post_rst_tie_rr", gcnt[0][0], 1);
      chk("post_rst_tie_fp", gcnt[1][0], 1);
      repeat (2) cycle();

      // Randomized traffic on both instances.
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
               if (!rv[k][p] && $urandom_range(0, 2) != 0) new_req(k, p);
         cycle();
      end
      for (int k = 0; k < 2; k++) rv[k] = '0;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between two requesters: port 0 is the core load/store path and port 1 is the host/test loader. It sequences the memory's exclusive read/write enables and its one-cycle registered read latency. It also rejects misaligned word accesses and returns a tagged response to the winning port. It sits between the requesters and the memory's `mem_addr`/`mem_r_enable`/`mem_w_enable`/`mem_wdata`/`mem_rdata` interface.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data word width
- `RR_ENABLE`, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  2  per-port request valid
- `req_ready`  out  2  per-port request accept; handshake = valid & ready at rising edge
- `req_we`  in  2  per-port 1 = write, 0 = read
- `req_addr`  in  2×ADDR_W  per-port byte address
- `req_wdata`  in  2×DATA_W  per-port write data
- `resp_valid`  out  2  per-port response pulse, one cycle, no backpressure
- `resp_err`  out  1  response is misaligned-access error; qualified by any `resp_valid`
- `resp_rdata`  out  DATA_W  read data; 0 for writes and errors
- `mem_addr`  out  ADDR_W  to memory
- `mem_r_enable`  out  1  to memory
- `mem_w_enable`  out  1  to memory
- `mem_wdata`  out  DATA_W  to memory
- `mem_rdata`  in  DATA_W  from memory, valid the cycle after a read enable

## Operation
- States: IDLE, RD_WAIT.
- IDLE with no `req_valid`: `req_ready`=0 and memory enables are 0.
- IDLE with any `req_valid`: pick a grant `g` and assert `req_ready[g]` combinationally. No other port sees ready.
- Grant policy when both ports are valid:
  - RR_ENABLE=1: grant the port not in `last_grant`.
  - RR_ENABLE=0: grant port 0.
- With a single valid port, that port is granted. `last_grant` updates on every handshake.
- Aligned read (`addr[1:0]`=0):
  - `mem_r_enable`=1, `mem_addr`=req_addr during the handshake cycle.
  - Next state is RD_WAIT and `g` is latched.
- Aligned write:
  - `mem_w_enable`=1, `mem_addr`, `mem_wdata` driven during the handshake cycle.
  - State stays IDLE; a write-ack response is scheduled.
- Misaligned request (either type): memory enables stay 0, state stays IDLE, and an error response is scheduled.
- RD_WAIT:
  - `req_ready`=0 and enables are 0.
  - Capture `mem_rdata` into the response register, schedule a read response to the latched `g`, return to IDLE.
- `mem_r_enable` and `mem_w_enable` are never both 1.

## Timing
- Handshake at edge T; memory samples its enables at edge T.
- Write ack: `resp_valid[g]` high during cycle T+1, with `resp_err`=0 and `resp_rdata`=0.
- Error response: `resp_valid[g]` high during cycle T+1, with `resp_err`=1 and `resp_rdata`=0.
- Read response:
  - RD_WAIT occupies cycle T+1; `mem_rdata` is sampled at edge T+1.
  - `resp_valid[g]` is high during cycle T+2 with the data.
- Throughput: writes and errors 1 per cycle; reads 1 per 2 cycles. A new grant may issue in the same cycle a read response is presented.
- Response outputs are registered; `resp_valid` is a single-cycle pulse, never held.
- Reset values: state=IDLE, `last_grant`=1 (port 0 wins first tie), `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
- While `rst_n`=0: `req_ready`=0, `mem_r_enable`=0, `mem_w_enable`=0.
- Reset asserted in RD_WAIT drops the pending read; no response is issued after reset release.
- Requests held valid without ready must keep their fields stable. The arbiter does not store unaccepted requests.

## Structure
- Package `dmem_arb_pkg`: state enum `{IDLE, RD_WAIT}`, `NUM_PORTS`=2, port-index typedef, response-kind enum `{RSP_RD, RSP_WR, RSP_ERR}`.
- Sub-module `rr_arbiter2`: combinational grant from `req_valid`, `last_grant` and `RR_ENABLE`. The grant register stays in `dmem_arbiter`.

## Test plan
- Port 0 writes 0xDEADBEEF to 0x10, then reads 0x10 → `mem_w_enable` pulse, ack at T+1; read `resp_valid[0]` at T+2 with 0xDEADBEEF, `resp_err`=0.
- Both ports hold valid reads (0x20, 0x40), RR_ENABLE=1 → grants alternate 0,1,0,1; one grant per 2 cycles; each response goes to the correct port only.
- Same traffic with RR_ENABLE=0 → port 0 granted every time and port 1 starved while port 0 stays valid.
- Port 1 reads 0x22 (misaligned) → no memory enable; `resp_valid[1]`, `resp_err`=1, `resp_rdata`=0 at T+1.
- Back-to-back writes from port 1 → one accept per cycle, acks each following cycle.
- `rst_n` pulsed low during RD_WAIT → enables and `req_ready` drop immediately; no `resp_valid` afterwards; first post-reset tie goes to port 0.
